pc_seq_ctrl: RTL and testbench

//  Owns the program counter and sequences every PC change: sequential, branch and jump.

---
 rtl/pc_seq_ctrl_if.sv | 11 +
 rtl/pc_seq_ctrl.sv | 114 +++++++++++
 tb/tb_pc_seq_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_ctrl_if.sv
// Data-memory read port used by pc_seq_ctrl to fetch memory-indirect branch/jump targets.
// The master raises mem_req with a stable mem_addr until the slave returns mem_ack with mem_rdata.
interface pc_seq_ctrl_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/pc_seq_ctrl.sv
// Program counter sequencer: sequential, direct (bz) and memory-indirect PC changes.
// Indirect targets are read over the mem port while the front end is stalled.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [2:0]           status,
    input  logic                 n,
    input  logic                 z,
    input  logic                 v,
    input  logic [25:0]          j_diraddr,
    input  logic [31:0]          tgt_addr,
    pc_seq_ctrl_if.master        mem,
    output logic [31:0]          pc,
    output logic                 stall,
    output logic                 link_we,
    output logic [31:0]          link_data,
    output logic                 sp_dec,
    output logic                 err
);

    typedef enum logic {RUN, WAIT} state_t;
    typedef enum logic [1:0] {KIND_PLAIN, KIND_JALM, KIND_JSPAL} kind_t;

    state_t      state;
    kind_t       kind;
    logic [7:0]  wait_cnt;
    logic [31:0] pc4;
    logic        take_indirect;
    logic        unused_v;

    // The overflow flag is reserved for future branch kinds.
    assign unused_v = v;
    assign pc4      = pc + 32'd4;
    assign stall    = (state != RUN);

    always_comb begin
        take_indirect = 1'b0;
        case (status)
            3'b001:                 take_indirect = n;
            3'b010:                 take_indirect = z;
            3'b100, 3'b101, 3'b110: take_indirect = 1'b1;
            default:                take_indirect = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            kind         <= KIND_PLAIN;
            wait_cnt     <= 8'd0;
            pc           <= RESET_PC;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= 32'd0;
            link_we      <= 1'b0;
            link_data    <= 32'd0;
            sp_dec       <= 1'b0;
            err          <= 1'b0;
        end else begin
            link_we <= 1'b0;
            sp_dec  <= 1'b0;
            err     <= 1'b0;
            case (state)
                RUN: begin
                    if (instr_valid) begin
                        if (take_indirect) begin
                            state        <= WAIT;
                            wait_cnt     <= 8'd0;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= tgt_addr;
                            link_data    <= pc4;
                            if (status == 3'b101)
                                kind <= KIND_JALM;
                            else if (status == 3'b110)
                                kind <= KIND_JSPAL;
                            else
                                kind <= KIND_PLAIN;
                        end else if (status == 3'b011 && z) begin
                            pc <= {pc4[31:28], j_diraddr, 2'b00};
                        end else begin
                            pc <= pc4;
                            if (status == 3'b111)
                                err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // An ack arriving on the last allowed cycle still wins over the abort.
                    if (mem.mem_ack) begin
                        pc          <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        state       <= RUN;
                        wait_cnt    <= 8'd0;
                        link_we     <= (kind != KIND_PLAIN);
                        sp_dec      <= (kind == KIND_JSPAL);
                    end else if (wait_cnt == TIMEOUT - 8'd1) begin
                        pc          <= link_data;
                        mem.mem_req <= 1'b0;
                        err         <= 1'b1;
                        state       <= RUN;
                        wait_cnt    <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus a randomized instruction
// stream compared against an arithmetic model of the PC rules.
module tb_pc_seq_ctrl;

    localparam logic [7:0] TB_TIMEOUT = 8'd4;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  status;
    logic        n_in, z_in, v_in;
    logic [25:0] j_diraddr;
    logic [31:0] tgt_addr;
    logic [31:0] pc;
    logic        stall, link_we, sp_dec, err;
    logic [31:0] link_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_pc;

    pc_seq_ctrl_if mem_bus ();

    pc_seq_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .status(status),
        .n(n_in), .z(z_in), .v(v_in), .j_diraddr(j_diraddr), .tgt_addr(tgt_addr),
        .mem(mem_bus), .pc(pc), .stall(stall), .link_we(link_we),
        .link_data(link_data), .sp_dec(sp_dec), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction for a single decode edge, then drop instr_valid.
    task automatic issue_instr(input logic [2:0] st, input logic nn, input logic zz,
                               input logic [25:0] dir, input logic [31:0] tgt);
        instr_valid = 1'b1; status = st; n_in = nn; z_in = zz; j_diraddr = dir; tgt_addr = tgt;
        @(posedge clk); #1;
        instr_valid = 1'b0; status = 3'b000;
    endtask

    task automatic wait_cycle(input logic ack, input logic [31:0] rdata);
        mem_bus.mem_ack = ack; mem_bus.mem_rdata = rdata;
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_bus.mem_req); end
        n_checks++; if (stall !== 1'b0 || err !== 1'b0 || link_we !== 1'b0 || sp_dec !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got stall=%b err=%b lwe=%b spd=%b expected 0", stall, err, link_we, sp_dec); end
        @(posedge clk); #1 rst_n = 1'b1;
        model_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            issue_instr(3'b000, 1'b0, 1'b0, 26'h0, 32'h0);
            model_pc = model_pc + 32'd4;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_stall: got %b expected 0", stall); end
        end
        n_checks++; if (pc !== 32'h14) begin n_fail++; $display("[TB] FAIL seq_pc: got %h expected %h", pc, 32'h14); end
    endtask

    task automatic test_bz();
        issue_instr(3'b011, 1'b0, 1'b1, 26'h40, 32'h0);
        model_pc = 32'h100;
        n_checks++; if (pc !== model_pc) begin n_fail++; $display("[TB] FAIL bz_first: got %h expected %h", pc, model_pc); end
        issue_instr(3'b011, 1'b0, 1'b1, 26'h40, 32'h0);
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("[TB] FAIL bz_taken: got %h expected %h", pc, 32'h100); end
        issue_instr(3'b011, 1'b0, 1'b0, 26'h40, 32'h0);
        model_pc = 32'h104;
        n_checks++; if (pc !== 32'h104) begin n_fail++; $display("[TB] FAIL bz_not_taken: got %h expected %h", pc, 32'h104); end
        // instr_valid low: pc holds and a stray ack in RUN does nothing.
        status = 3'b011; z_in = 1'b1; j_diraddr = 26'h3FF;
        wait_cycle(1'b1, 32'hDEAD_BEEF);
        status = 3'b000;
        n_checks++; if (pc !== 32'h104 || mem_bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_hold: got pc=%h req=%b expected %h req=0", pc, mem_bus.mem_req, 32'h104); end
    endtask

    task automatic test_jalm();
        int stall_cycles;
        issue_instr(3'b011, 1'b0, 1'b1, 26'h80, 32'h0);
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("[TB] FAIL jalm_setup: got %h expected %h", pc, 32'h200); end
        issue_instr(3'b101, 1'b0, 1'b0, 26'h0, 32'h80);
        stall_cycles = 0;
        for (int w = 1; w <= 3; w++) begin
            if (stall === 1'b1) stall_cycles++;
            n_checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h80) begin n_fail++; $display("[TB] FAIL jalm_req: got req=%b addr=%h expected 1 %h", mem_bus.mem_req, mem_bus.mem_addr, 32'h80); end
            tgt_addr = $urandom; instr_valid = 1'b1; status = 3'(($urandom));
            wait_cycle(w == 3, (w == 3) ? 32'h3000 : $urandom);
            instr_valid = 1'b0; status = 3'b000;
        end
        model_pc = 32'h3000;
        n_checks++; if (stall_cycles != 3 || stall !== 1'b0) begin n_fail++; $display("[TB] FAIL jalm_stall: got %0d cycles stall=%b expected 3 cycles then 0", stall_cycles, stall); end
        n_checks++; if (pc !== 32'h3000) begin n_fail++; $display("[TB] FAIL jalm_pc: got %h expected %h", pc, 32'h3000); end
        n_checks++; if (link_we !== 1'b1 || link_data !== 32'h204 || sp_dec !== 1'b0) begin n_fail++; $display("[TB] FAIL jalm_link: got we=%b data=%h spd=%b expected 1 %h 0", link_we, link_data, sp_dec, 32'h204); end
        n_checks++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL jalm_req_drop: got %b expected 0", mem_bus.mem_req); end
    endtask

    task automatic test_not_taken();
        issue_instr(3'b001, 1'b0, 1'b1, 26'h0, 32'h55);
        n_checks++; if (pc !== 32'h3004 || mem_bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL bmn_not_taken: got pc=%h req=%b expected %h req=0", pc, mem_bus.mem_req, 32'h3004); end
        issue_instr(3'b010, 1'b1, 1'b0, 26'h0, 32'h66);
        n_checks++; if (pc !== 32'h3008 || mem_bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL brz_not_taken: got pc=%h req=%b expected %h req=0", pc, mem_bus.mem_req, 32'h3008); end
        issue_instr(3'b110, 1'b0, 1'b0, 26'h0, 32'h400);
        wait_cycle(1'b1, 32'h4000);
        model_pc = 32'h4000;
        n_checks++; if (pc !== 32'h4000) begin n_fail++; $display("[TB] FAIL jspal_pc: got %h expected %h", pc, 32'h4000); end
        n_checks++; if (sp_dec !== 1'b1 || link_we !== 1'b1 || link_data !== 32'h300C) begin n_fail++; $display("[TB] FAIL jspal_pulse: got spd=%b we=%b data=%h expected 1 1 %h", sp_dec, link_we, link_data, 32'h300C); end
        @(posedge clk); #1;
        n_checks++; if (sp_dec !== 1'b0 || link_we !== 1'b0) begin n_fail++; $display("[TB] FAIL jspal_one_cycle: got spd=%b we=%b expected 0 0", sp_dec, link_we); end
    endtask

    task automatic test_timeout();
        int err_cycle;
        err_cycle = -1;
        issue_instr(3'b100, 1'b0, 1'b0, 26'h0, 32'h900);
        for (int c = 1; c <= 10 && err_cycle < 0; c++) begin
            wait_cycle(1'b0, 32'h0);
            if (err === 1'b1) err_cycle = c;
        end
        model_pc = 32'h4004;
        n_checks++; if (err_cycle != int'(TB_TIMEOUT)) begin n_fail++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", err_cycle, TB_TIMEOUT); end
        n_checks++; if (pc !== 32'h4004 || mem_bus.mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_state: got pc=%h req=%b stall=%b expected %h 0 0", pc, mem_bus.mem_req, stall, 32'h4004); end
        n_checks++; if (link_we !== 1'b0 || sp_dec !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_link: got we=%b spd=%b expected 0 0", link_we, sp_dec); end
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_err_pulse: got %b expected 0", err); end
    endtask

    task automatic test_illegal_wrap();
        issue_instr(3'b111, 1'b1, 1'b1, 26'h0, 32'h0);
        n_checks++; if (pc !== 32'h4008 || err !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal: got pc=%h err=%b expected %h 1", pc, err, 32'h4008); end
        issue_instr(3'b100, 1'b0, 1'b0, 26'h0, 32'h10);
        wait_cycle(1'b1, 32'hFFFF_FFFC);
        n_checks++; if (pc !== 32'hFFFF_FFFC || link_we !== 1'b0) begin n_fail++; $display("[TB] FAIL jmor_pc: got pc=%h we=%b expected %h 0", pc, link_we, 32'hFFFF_FFFC); end
        issue_instr(3'b000, 1'b0, 1'b0, 26'h0, 32'h0);
        model_pc = 32'h0;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap: got %h expected %h", pc, 32'h0); end
    endtask

    task automatic test_random();
        logic [2:0]  st;
        logic        nn, zz, indirect, is_link;
        logic [25:0] dir;
        logic [31:0] tgt, pc4, exp_pc, rdata;
        int          k;
        for (int i = 0; i < 40; i++) begin
            st = 3'($urandom); nn = 1'($urandom); zz = 1'($urandom);
            dir = 26'($urandom); tgt = $urandom;
            pc4 = model_pc + 32'd4;
            indirect = (st >= 3'd4 && st <= 3'd6) || (st == 3'd1 && nn) || (st == 3'd2 && zz);
            is_link = (st == 3'd5) || (st == 3'd6);
            issue_instr(st, nn, zz, dir, tgt);
            if (!indirect) begin
                exp_pc = (st == 3'd3 && zz) ? ((pc4 & 32'hF000_0000) | ({6'b0, dir} << 2)) : pc4;
                n_checks++; if (pc !== exp_pc || err !== (st == 3'd7) || mem_bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_direct st=%0d: got pc=%h err=%b req=%b expected %h %b 0", st, pc, err, mem_bus.mem_req, exp_pc, st == 3'd7); end
                model_pc = exp_pc;
            end else begin
                k = $urandom_range(1, int'(TB_TIMEOUT));
                rdata = $urandom;
                for (int w = 1; w <= k; w++) begin
                    n_checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== tgt || stall !== 1'b1) begin n_fail++; $display("[TB] FAIL rand_wait st=%0d: got req=%b addr=%h stall=%b expected 1 %h 1", st, mem_bus.mem_req, mem_bus.mem_addr, stall, tgt); end
                    tgt_addr = $urandom; instr_valid = 1'(($urandom)); status = 3'($urandom);
                    wait_cycle(w == k, (w == k) ? rdata : $urandom);
                    instr_valid = 1'b0; status = 3'b000;
                end
                n_checks++; if (pc !== rdata || stall !== 1'b0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_indirect st=%0d k=%0d: got pc=%h stall=%b err=%b expected %h 0 0", st, k, pc, stall, err, rdata); end
                n_checks++; if (link_we !== is_link || sp_dec !== (st == 3'd6) || (is_link && link_data !== pc4)) begin n_fail++; $display("[TB] FAIL rand_link st=%0d: got we=%b spd=%b data=%h expected %b %b %h", st, link_we, sp_dec, link_data, is_link, st == 3'd6, pc4); end
                model_pc = rdata;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        issue_instr(3'b100, 1'b0, 1'b0, 26'h0, 32'hABC0);
        wait_cycle(1'b0, 32'h0);
        wait_cycle(1'b0, 32'h0);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h7777_0000;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0 || mem_bus.mem_req !== 1'b0 || stall !== 1'b0 || link_data !== 32'h0) begin n_fail++; $display("[TB] FAIL async_reset: got pc=%h req=%b stall=%b ld=%h expected 0 0 0 0", pc, mem_bus.mem_req, stall, link_data); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
        n_checks++; if (pc !== 32'h0 || mem_bus.mem_req !== 1'b0 || link_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_after_reset: got pc=%h req=%b we=%b expected 0 0 0", pc, mem_bus.mem_req, link_we); end
        model_pc = 32'h0;
    endtask

    initial begin
        rst_n = 1'b1; instr_valid = 1'b0; status = 3'b000;
        n_in = 1'b0; z_in = 1'b0; v_in = 1'b0; j_diraddr = 26'h0; tgt_addr = 32'h0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
        model_pc = 32'h0;
        test_reset();
        test_bz();
        test_jalm();
        test_not_taken();
        test_timeout();
        test_illegal_wrap();
        test_random();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
